// File: rtl/wb_reg_write_demux.sv
//------------------------------------------------------------------------------
// Module      : wb_reg_write_demux
// Description : Registered 1-to-32 register-file write-enable demux with a
//               one-cycle forwarding stage and saturating commit counter.
//               Define WB_XZR_SUPPRESS_EN to treat row 31 as XZR (no write).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_reg_write_demux #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  stall,
  output logic [31:0]           reg_we,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  fwd_valid,
  output logic [4:0]            fwd_addr,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic [15:0]           wr_count
);

  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  logic                  w_accept;
  logic [3:0]            w_grp_sel;
  logic [7:0]            w_row_sel;
  logic [31:0]           w_dec;
  logic [4:0]            w_enc;

  logic [31:0]           r_reg_we;
  logic [DATA_WIDTH-1:0] r_reg_wdata;
  logic                  r_fwd_valid;
  logic [4:0]            r_fwd_addr;
  logic [DATA_WIDTH-1:0] r_fwd_data;
  logic [15:0]           r_wr_count;

`ifdef WB_XZR_SUPPRESS_EN
  assign w_accept = wr_en && (wr_addr != 5'd31);
`else
  assign w_accept = wr_en;
`endif

  // 2-to-4 group stage carries the accept gate; 3-to-8 row stage is shared
  always_comb begin
    w_grp_sel = 4'b0000;
    if (w_accept) w_grp_sel[wr_addr[4:3]] = 1'b1;
  end

  assign w_row_sel = 8'b0000_0001 << wr_addr[2:0];

  generate
    for (genvar g = 0; g < 4; g++) begin : g_grp
      assign w_dec[g*8 +: 8] = w_row_sel & {8{w_grp_sel[g]}};
    end
  endgenerate

  // reg_we is one-hot or zero, so OR-ing the indices of set bits encodes it
  always_comb begin
    w_enc = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (r_reg_we[i]) w_enc = w_enc | 5'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reg_we    <= '0;
      r_reg_wdata <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_addr  <= 5'd0;
      r_fwd_data  <= '0;
      r_wr_count  <= 16'd0;
    end else if (stall) begin
      r_reg_we <= '0;
    end else begin
      r_reg_we    <= w_dec;
      if (wr_en) r_reg_wdata <= wr_data;
      r_fwd_valid <= |r_reg_we;
      r_fwd_addr  <= w_enc;
      r_fwd_data  <= r_reg_wdata;
      if (w_accept && (r_wr_count != c_CNT_MAX)) r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign reg_we    = r_reg_we;
  assign reg_wdata = r_reg_wdata;
  assign fwd_valid = r_fwd_valid;
  assign fwd_addr  = r_fwd_addr;
  assign fwd_data  = r_fwd_data;
  assign wr_count  = r_wr_count;

endmodule

`default_nettype wire

// File: tb/tb_wb_reg_write_demux.sv
//------------------------------------------------------------------------------
// Module      : tb_wb_reg_write_demux
// Description : Scoreboard bench for wb_reg_write_demux (directed + random).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_reg_write_demux;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          stall;
  logic [31:0]   reg_we;
  logic [DW-1:0] reg_wdata;
  logic          fwd_valid;
  logic [4:0]    fwd_addr;
  logic [DW-1:0] fwd_data;
  logic [15:0]   wr_count;

  wb_reg_write_demux #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .stall(stall), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   we;
    logic [DW-1:0] wdata;
    logic          fv;
    logic [4:0]    fa;
    logic [DW-1:0] fd;
    logic [15:0]   cnt;
  } exp_t;

  exp_t  q[$];
  exp_t  m;
  int    m_last_addr;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m.we = '0; m.wdata = '0; m.fv = 1'b0; m.fa = '0; m.fd = '0; m.cnt = '0;
    m_last_addr = 0;
  endtask

  // Reference: the write issued last cycle becomes the forwarded write;
  // a new accepted request becomes a one-hot pulse and a counted commit.
  task automatic cyc(input logic en, input int addr, input logic [DW-1:0] data, input logic st);
    bit acc;
    wr_en = en; wr_addr = addr[4:0]; wr_data = data; stall = st;
    @(posedge clk);
`ifdef WB_XZR_SUPPRESS_EN
    acc = en && (addr != 31);
`else
    acc = en;
`endif
    if (st) begin
      m.we = '0;
    end else begin
      m.fv = (m.we != 0);
      m.fa = m.fv ? m_last_addr[4:0] : 5'd0;
      m.fd = m.wdata;
      m.we = acc ? (32'd1 << addr) : 32'd0;
      if (acc) m_last_addr = addr;
      if (en) m.wdata = data;
      if (acc && m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
    end
    q.push_back(m);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " reg_we"},    64'(reg_we),    64'd0);
    check({tag, " reg_wdata"}, reg_wdata,      64'd0);
    check({tag, " fwd_valid"}, 64'(fwd_valid), 64'd0);
    check({tag, " fwd_addr"},  64'(fwd_addr),  64'd0);
    check({tag, " fwd_data"},  fwd_data,       64'd0);
    check({tag, " wr_count"},  64'(wr_count),  64'd0);
  endtask

  // Monitor: DUT presents a fresh output set every cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("reg_we",    64'(reg_we),    64'(e.we));
      check("reg_wdata", reg_wdata,      e.wdata);
      check("fwd_valid", 64'(fwd_valid), 64'(e.fv));
      check("fwd_addr",  64'(fwd_addr),  64'(e.fa));
      check("fwd_data",  fwd_data,       e.fd);
      check("wr_count",  64'(wr_count),  64'(e.cnt));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; stall = 1'b0;
    model_reset();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // decode sweep
    for (int a = 0; a < 31; a++) cyc(1'b1, a, 64'(a) * 64'h1111, 1'b0);
    cyc(1'b0, 0, '0, 1'b0);

    // idle after write to X3
    cyc(1'b1, 3, 64'hDEAD_BEEF_0000_0003, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, int'($urandom_range(0, 31)), {$urandom, $urandom}, 1'b0);

    // stall holds the write, then issues it exactly once
    for (int i = 0; i < 3; i++) cyc(1'b1, 5, 64'h5555_AAAA_5555_AAAA, 1'b1);
    cyc(1'b1, 5, 64'h5555_AAAA_5555_AAAA, 1'b0);
    cyc(1'b0, 0, '0, 1'b0);
    cyc(1'b0, 0, '0, 1'b0);

    // XZR / register 31
    cyc(1'b1, 31, 64'h3131_3131_3131_3131, 1'b0);
    cyc(1'b0, 0, '0, 1'b0);
    cyc(1'b0, 0, '0, 1'b0);

    // back-to-back writes to the same row
    cyc(1'b1, 9, 64'h1, 1'b0);
    cyc(1'b1, 9, 64'h2, 1'b0);
    cyc(1'b0, 0, '0, 1'b0);

    // asynchronous reset while reg_we = 0x20
    cyc(1'b1, 5, 64'hCAFE_0005, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h7777; stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    cyc(1'b0, 7, 64'h7777, 1'b0);
    cyc(1'b0, 0, '0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), {$urandom, $urandom},
          ($urandom_range(0, 3) == 0));

    // saturation
    for (int i = 0; i < 65537; i++)
      cyc(1'b1, int'($urandom_range(0, 30)), {$urandom, $urandom}, 1'b0);
    cyc(1'b1, 4, 64'h4, 1'b0);
    cyc(1'b0, 0, '0, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
